ring_monitor: RTL and testbench

RING_MONITOR -- requirements
Module: ring_monitor

---
 rtl/ring_monitor.sv | 228 ++++++++++++++++++++++
 tb/tb_ring_monitor.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_monitor.sv
// ring_monitor
// Watches a one-hot ring counter driven by an upstream block and checks that it
// rotates one position per enabled sample ({r[WIDTH-2:0], r[WIDTH-1]}).
// After LOCK_STEPS consecutive legal rotations it declares lock and counts
// completed revolutions. Any corruption while locked drops into FAULT and asks
// the upstream counter to re-initialise. FAULT is left only on a sample with
// the MSB alone set, which is the ring's natural restart value.
//
// Build option:
//   RING_MONITOR_STICKY_ERR_EN - when defined, err_onehot / err_step hold once
//   set and are cleared only by init. The FSM behaves the same either way.
module ring_monitor #(
   parameter int WIDTH      = 8,   // ring width, power of two, >= 4
   parameter int LOCK_STEPS = 8,   // consecutive legal rotations needed to lock
   parameter int REV_W      = 16   // revolution counter width
) (
   input  logic                     clk,
   input  logic                     init,
   input  logic                     en,
   input  logic [WIDTH-1:0]         ring_in,
   output logic [$clog2(WIDTH)-1:0] phase,
   output logic                     phase_valid,
   output logic                     locked,
   output logic                     rev_tick,
   output logic [REV_W-1:0]         rev_count,
   output logic                     err_onehot,
   output logic                     err_step,
   output logic                     resync_req
);

   localparam int PHASE_W = $clog2(WIDTH);
   localparam int STEP_W  = $clog2(LOCK_STEPS + 1);

   localparam logic [WIDTH-1:0]  RING_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0]  MSB_ONLY  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LOCK_STEPS - 1);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
   localparam logic [REV_W-1:0]  REV_ONE   = REV_W'(1);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_FAULT    = 2'd2
   } state_t;

   // Registered state
   state_t              state_q;
   logic [WIDTH-1:0]    prev_q;
   logic                prev_valid_q;
   logic [STEP_W-1:0]   step_q;
   logic [PHASE_W-1:0]  phase_q;
   logic                phase_valid_q;
   logic                locked_q;
   logic                rev_tick_q;
   logic [REV_W-1:0]    rev_count_q;
   logic                err_onehot_q;
   logic                err_step_q;
   logic                resync_q;

   // Next-state values
   state_t              state_d;
   logic [WIDTH-1:0]    prev_d;
   logic                prev_valid_d;
   logic [STEP_W-1:0]   step_d;
   logic [PHASE_W-1:0]  phase_d;
   logic                phase_valid_d;
   logic                rev_tick_d;
   logic [REV_W-1:0]    rev_count_d;
   logic                err_onehot_d;
   logic                err_step_d;

   // Sample decode
   logic                is_onehot;
   logic                is_legal;
   logic                is_wrap;
   logic [WIDTH-1:0]    prev_rot;
   logic [PHASE_W-1:0]  sample_idx;
   logic                onehot_hit;
   logic                step_hit;

   // Classify the incoming sample against the last accepted one.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' so later lines see the
      // value just computed; clocked blocks use '<=' so every flop samples
      // pre-edge values regardless of statement order.
      prev_rot  = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
      is_onehot = (ring_in != '0) && ((ring_in & (ring_in - RING_ONE)) == '0);
      is_legal  = is_onehot && prev_valid_q && (ring_in == prev_rot);
      is_wrap   = prev_q[WIDTH-2] & ring_in[WIDTH-1];
   end

   // Encode the position of the set bit; only meaningful when one-hot.
   always_comb begin
      sample_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (ring_in[i]) begin
            sample_idx = sample_idx | PHASE_W'(i);
         end
      end
   end

   // Next-state and next-output logic for the lock FSM.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d       = state_q;
      prev_d        = prev_q;
      prev_valid_d  = prev_valid_q;
      step_d        = step_q;
      phase_d       = phase_q;
      phase_valid_d = phase_valid_q;
      rev_count_d   = rev_count_q;
      rev_tick_d    = 1'b0;
      onehot_hit    = 1'b0;
      step_hit      = 1'b0;

      if (en) begin
         case (state_q)
            ST_FAULT: begin
               // Wait for the upstream ring to restart at the MSB; everything
               // else is ignored and raises no error.
               if (ring_in == MSB_ONLY) begin
                  state_d      = ST_UNLOCKED;
                  prev_d       = ring_in;
                  prev_valid_d = 1'b1;
                  step_d       = '0;
               end
            end

            default: begin
               if (!is_onehot) begin
                  // Corrupt sample: phase keeps its old index but is no
                  // longer trusted, and prev is left untouched.
                  onehot_hit    = 1'b1;
                  phase_valid_d = 1'b0;
                  if (state_q == ST_LOCKED) begin
                     state_d = ST_FAULT;
                  end else begin
                     step_d = '0;
                  end
               end else begin
                  phase_d       = sample_idx;
                  phase_valid_d = 1'b1;
                  prev_d        = ring_in;
                  prev_valid_d  = 1'b1;

                  // The first one-hot sample after init only seeds prev.
                  if (prev_valid_q) begin
                     if (is_legal) begin
                        if (state_q == ST_LOCKED) begin
                           if (is_wrap) begin
                              rev_tick_d  = 1'b1;
                              rev_count_d = rev_count_q + REV_ONE;
                           end
                        end else if (step_q == STEP_LAST) begin
                           state_d     = ST_LOCKED;
                           step_d      = '0;
                           rev_count_d = '0;
                        end else begin
                           step_d = step_q + STEP_ONE;
                        end
                     end else begin
                        step_hit = 1'b1;
                        if (state_q == ST_LOCKED) begin
                           state_d       = ST_FAULT;
                           phase_valid_d = 1'b0;
                        end else begin
                           step_d = '0;
                        end
                     end
                  end
               end
            end
         endcase
      end

`ifdef RING_MONITOR_STICKY_ERR_EN
      // Flags accumulate until init; a one-hot error outranks a step error
      // so the two are never reported together.
      err_onehot_d = err_onehot_q | onehot_hit;
      err_step_d   = (err_step_q | step_hit) & ~err_onehot_d;
`else
      err_onehot_d = onehot_hit;
      err_step_d   = step_hit & ~onehot_hit;
`endif
   end

   // State and output registers; init overrides every other input.
   always_ff @(posedge clk) begin
      if (init) begin
         state_q       <= ST_UNLOCKED;
         prev_q        <= '0;
         prev_valid_q  <= 1'b0;
         step_q        <= '0;
         phase_q       <= '0;
         phase_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         rev_tick_q    <= 1'b0;
         rev_count_q   <= '0;
         err_onehot_q  <= 1'b0;
         err_step_q    <= 1'b0;
         resync_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_q        <= prev_d;
         prev_valid_q  <= prev_valid_d;
         step_q        <= step_d;
         phase_q       <= phase_d;
         phase_valid_q <= phase_valid_d;
         locked_q      <= (state_d == ST_LOCKED);
         rev_tick_q    <= rev_tick_d;
         rev_count_q   <= rev_count_d;
         err_onehot_q  <= err_onehot_d;
         err_step_q    <= err_step_d;
         resync_q      <= (state_d == ST_FAULT);
      end
   end

   assign phase       = phase_q;
   assign phase_valid = phase_valid_q;
   assign locked      = locked_q;
   assign rev_tick    = rev_tick_q;
   assign rev_count   = rev_count_q;
   assign err_onehot  = err_onehot_q;
   assign err_step    = err_step_q;
   assign resync_req  = resync_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor (WIDTH 8, LOCK_STEPS 8).
// A behavioural model predicts every output for each driven sample; the
// prediction is queued and compared one cycle later. Directed checks against
// fixed values cover lock, revolution counting, fault entry/exit and init.
// A second instance with REV_W=2 shares the stimulus to exercise wrap-around.
module tb_ring_monitor;

`ifdef RING_MONITOR_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic        clk;
   logic        init;
   logic        en;
   logic [7:0]  ring_in;

   logic [2:0]  phase;
   logic        phase_valid;
   logic        locked;
   logic        rev_tick;
   logic [15:0] rev_count;
   logic        err_onehot;
   logic        err_step;
   logic        resync_req;

   logic [2:0]  r2_phase;
   logic        r2_phase_valid;
   logic        r2_locked;
   logic        r2_rev_tick;
   logic [1:0]  r2_rev_count;
   logic        r2_err_onehot;
   logic        r2_err_step;
   logic        r2_resync_req;

   ring_monitor #(.WIDTH(8), .LOCK_STEPS(8), .REV_W(16)) u_dut (
      .clk         (clk),
      .init        (init),
      .en          (en),
      .ring_in     (ring_in),
      .phase       (phase),
      .phase_valid (phase_valid),
      .locked      (locked),
      .rev_tick    (rev_tick),
      .rev_count   (rev_count),
      .err_onehot  (err_onehot),
      .err_step    (err_step),
      .resync_req  (resync_req)
   );

   ring_monitor #(.WIDTH(8), .LOCK_STEPS(8), .REV_W(2)) u_rev2 (
      .clk         (clk),
      .init        (init),
      .en          (en),
      .ring_in     (ring_in),
      .phase       (r2_phase),
      .phase_valid (r2_phase_valid),
      .locked      (r2_locked),
      .rev_tick    (r2_rev_tick),
      .rev_count   (r2_rev_count),
      .err_onehot  (r2_err_onehot),
      .err_step    (r2_err_step),
      .resync_req  (r2_resync_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] phase;
      bit         phv;
      bit         locked;
      bit         tick;
      int         rev;
      bit         eo;
      bit         es;
      bit         resync;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: 0 unlocked, 1 locked, 2 fault
   int         m_state;
   logic [7:0] m_prev;
   bit         m_pv;
   int         m_step;
   logic [2:0] m_phase;
   bit         m_phv;
   int         m_rev;
   bit         m_tick;
   bit         m_eo;
   bit         m_es;

   logic [7:0] cur;
   int         ticks;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Advance the behavioural model by one clock edge.
   task automatic model_step(input logic i, input logic e, input logic [7:0] r);
      bit n_eo;
      bit n_es;
      n_eo   = 1'b0;
      n_es   = 1'b0;
      m_tick = 1'b0;
      if (i) begin
         m_state = 0; m_prev = '0; m_pv = 0; m_step = 0;
         m_phase = '0; m_phv = 0; m_rev = 0; m_eo = 0; m_es = 0;
      end else begin
         if (e) begin
            if (m_state == 2) begin
               if (r == 8'h80) begin
                  m_state = 0; m_prev = r; m_pv = 1; m_step = 0;
               end
            end else if ($countones(r) != 1) begin
               n_eo  = 1'b1;
               m_phv = 1'b0;
               if (m_state == 1) m_state = 2;
               else m_step = 0;
            end else begin
               for (int k = 0; k < 8; k++) begin
                  if (r[k]) m_phase = 3'(k);
               end
               m_phv = 1'b1;
               if (m_pv && (r == {m_prev[6:0], m_prev[7]})) begin
                  if (m_state == 1) begin
                     if (r == 8'h80) begin
                        m_tick = 1'b1;
                        m_rev  = (m_rev + 1) % 65536;
                     end
                  end else begin
                     m_step++;
                     if (m_step == 8) begin
                        m_state = 1; m_step = 0; m_rev = 0;
                     end
                  end
               end else if (m_pv) begin
                  n_es = 1'b1;
                  if (m_state == 1) begin
                     m_state = 2;
                     m_phv   = 1'b0;
                  end else begin
                     m_step = 0;
                  end
               end
               m_prev = r;
               m_pv   = 1'b1;
            end
         end
         if (STICKY) begin
            m_eo = m_eo | n_eo;
            m_es = (m_es | n_es) & !m_eo;
         end else begin
            m_eo = n_eo;
            m_es = n_es;
         end
      end
   endtask

   // Compare the oldest prediction with what the DUTs show now.
   task automatic compare_head();
      exp_t x;
      if (sb.size() == 0) return;
      x = sb.pop_front();
      check("sb_phase",       phase,        x.phase);
      check("sb_phase_valid", phase_valid,  x.phv);
      check("sb_locked",      locked,       x.locked);
      check("sb_rev_tick",    rev_tick,     x.tick);
      check("sb_rev_count",   rev_count,    x.rev);
      check("sb_err_onehot",  err_onehot,   x.eo);
      check("sb_err_step",    err_step,     x.es);
      check("sb_resync_req",  resync_req,   x.resync);
      check("sb_rev2_count",  r2_rev_count, x.rev % 4);
      check("sb_rev2_tick",   r2_rev_tick,  x.tick);
   endtask

   // Drive one sample on the falling edge, queue its prediction, and return
   // just after the rising edge that samples it.
   task automatic drive(input logic i, input logic e, input logic [7:0] r);
      exp_t x;
      @(negedge clk);
      compare_head();
      init    = i;
      en      = e;
      ring_in = r;
      model_step(i, e, r);
      x.phase  = m_phase;
      x.phv    = m_phv;
      x.locked = (m_state == 1);
      x.tick   = m_tick;
      x.rev    = m_rev;
      x.eo     = m_eo;
      x.es     = m_es;
      x.resync = (m_state == 2);
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // Next clean rotation step of the ring.
   task automatic adv();
      cur = {cur[6:0], cur[7]};
      drive(1'b0, 1'b1, cur);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_phase"},       phase,        0);
      check({tag, "_phase_valid"}, phase_valid,  0);
      check({tag, "_locked"},      locked,       0);
      check({tag, "_rev_tick"},    rev_tick,     0);
      check({tag, "_rev_count"},   rev_count,    0);
      check({tag, "_err_onehot"},  err_onehot,   0);
      check({tag, "_err_step"},    err_step,     0);
      check({tag, "_resync_req"},  resync_req,   0);
      check({tag, "_rev2_count"},  r2_rev_count, 0);
   endtask

   initial begin
      init    = 1'b1;
      en      = 1'b0;
      ring_in = '0;

      // Reset, including init with en=1 and a plausible sample present
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 8'h80);
      check_reset("rst");

      // Seed at 0x80, then eight legal steps reach lock
      cur = 8'h80;
      drive(1'b0, 1'b1, cur);
      check("seed_phase", phase, 7);
      check("seed_phase_valid", phase_valid, 1);
      for (int k = 1; k <= 8; k++) begin
         adv();
         check("lock_phase", phase, (k + 7) % 8);
         if (k == 7) check("not_locked_at_7", locked, 0);
      end
      check("locked_at_8", locked, 1);
      check("rev_at_lock", rev_count, 0);

      // Two full revolutions while locked
      ticks = 0;
      for (int k = 0; k < 16; k++) begin
         adv();
         ticks += int'(rev_tick);
      end
      check("tick_count", ticks, 2);
      check("rev_two", rev_count, 2);
      check("rev2_two", r2_rev_count, 2);

      // Three more revolutions: narrow counter goes 3,0,1
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 8; k++) adv();
         check("rev_seq", rev_count, 3 + r);
         check("rev2_seq", r2_rev_count, (3 + r) % 4);
      end

      // Enable gaps carrying junk must be ignored
      adv();
      drive(1'b0, 1'b0, 8'h55);
      check("gap_phase", phase, 0);
      check("gap_phase_valid", phase_valid, 1);
      check("gap_err_step", err_step, 0);
      adv();
      check("after_gap_err_step", err_step, 0);
      check("after_gap_phase", phase, 1);
      drive(1'b0, 1'b0, 8'h00);
      check("gap_err_onehot", err_onehot, 0);
      adv();
      check("still_locked", locked, 1);

      // Non-one-hot while locked -> FAULT
      drive(1'b0, 1'b1, 8'h03);
      check("oh_err_onehot", err_onehot, 1);
      check("oh_err_step", err_step, 0);
      check("oh_locked", locked, 0);
      check("oh_resync", resync_req, 1);
      check("oh_phase_valid", phase_valid, 0);
      drive(1'b0, 1'b1, 8'h04);
      check("fault_ignore_eo", err_onehot, STICKY);
      check("fault_ignore_es", err_step, 0);
      check("fault_hold_resync", resync_req, 1);
      drive(1'b0, 1'b1, 8'h80);
      cur = 8'h80;
      check("exit_resync", resync_req, 0);
      check("exit_locked", locked, 0);

      // Relock, then a skipped position while locked -> FAULT
      for (int k = 0; k < 8; k++) adv();
      check("relock", locked, 1);
      adv();
      adv();
      drive(1'b0, 1'b1, 8'h08);
      check("skip_err_step", err_step, STICKY ? 0 : 1);
      check("skip_err_onehot", err_onehot, STICKY);
      check("skip_resync", resync_req, 1);
      check("skip_locked", locked, 0);

      // Repeat while unlocked: step error, counter cleared, no fault
      drive(1'b0, 1'b1, 8'h80);
      cur = 8'h80;
      adv();
      adv();
      drive(1'b0, 1'b1, 8'h02);
      check("repeat_err_step", err_step, STICKY ? 0 : 1);
      check("repeat_locked", locked, 0);
      check("repeat_resync", resync_req, 0);
      for (int k = 1; k <= 8; k++) begin
         adv();
         if (k == 7) check("recount_not_locked", locked, 0);
      end
      check("recount_locked", locked, 1);

      // init with en=1 mid-rotation
      adv();
      adv();
      drive(1'b1, 1'b1, 8'h10);
      check_reset("mid_init");

      // Lock again, inject all-zero, then init from FAULT
      cur = 8'h80;
      drive(1'b0, 1'b1, cur);
      for (int k = 0; k < 8; k++) adv();
      check("zero_pre_locked", locked, 1);
      drive(1'b0, 1'b1, 8'h00);
      check("zero_err_onehot", err_onehot, 1);
      check("zero_resync", resync_req, 1);
      drive(1'b0, 1'b0, 8'h00);
      check("zero_hold_resync", resync_req, 1);
      drive(1'b0, 1'b1, 8'h80);
      check("zero_sticky", err_onehot, STICKY);
      check("zero_exit_resync", resync_req, 0);
      drive(1'b0, 1'b1, 8'h03);
      drive(1'b1, 1'b1, 8'h80);
      check_reset("fault_init");

      drive(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      compare_head();
      if (sb.size() != 0) check("sb_drain", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
